// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit memory master.
// Size, error and FSM state enums used across the LSU.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_SIZE     = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
// Also flags misaligned accesses and illegal sizes.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  output logic        illegal_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  always_comb begin
    wmask_o    = 4'b0000;
    wdata_o    = 32'h0;
    misalign_o = 1'b0;
    illegal_o  = 1'b0;
    rdata_o    = 32'h0;
    shifted    = rdata_i >> {off_i, 3'b000};
    unique case (size_i)
      SZ_B: begin
        wmask_o = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = uns_i ? {24'h0, shifted[7:0]}
                        : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        misalign_o = off_i[0];
        wmask_o    = 4'b0011 << off_i;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = uns_i ? {16'h0, shifted[15:0]}
                           : {{16{shifted[15]}}, shifted[15:0]};
      end
      SZ_W: begin
        misalign_o = |off_i;
        wmask_o    = 4'hF;
        wdata_o    = wdata_i;
        rdata_o    = shifted;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Data-memory initiator: one outstanding load/store, with timeout.
// FSM IDLE -> REQ -> RESP; errors skip REQ entirely.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        mem_valid,
  output logic        mem_write_enable,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [15:0] TO = 16'(TIMEOUT_CYCLES);

  state_e      state_q;
  err_e        err_q;
  logic        wr_q;
  logic [1:0]  sz_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [31:0] rdata_q;

  logic        idle;
  logic [1:0]  a_size;
  logic        a_uns;
  logic [1:0]  a_off;
  logic [31:0] a_wdata;
  logic [3:0]  a_wmask;
  logic [31:0] a_wdo;
  logic        a_mis;
  logic        a_ill;
  logic [31:0] a_rdata;

  // In IDLE the aligner checks the live request; afterwards the latched one.
  assign idle    = (state_q == IDLE);
  assign a_size  = idle ? req_size        : sz_q;
  assign a_uns   = idle ? req_unsigned    : uns_q;
  assign a_off   = idle ? req_addr[1:0]   : addr_q[1:0];
  assign a_wdata = idle ? req_wdata       : wdata_q;
  assign cnt_d   = cnt_q + 16'd1;

  lsu_align u_align (
    .size_i     (a_size),
    .uns_i      (a_uns),
    .off_i      (a_off),
    .wdata_i    (a_wdata),
    .rdata_i    (mem_rdata),
    .wmask_o    (a_wmask),
    .wdata_o    (a_wdo),
    .misalign_o (a_mis),
    .illegal_o  (a_ill),
    .rdata_o    (a_rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      err_q   <= ERR_OK;
      wr_q    <= 1'b0;
      sz_q    <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      cnt_q   <= 16'h0;
      rdata_q <= 32'h0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            sz_q    <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= 16'h0;
            rdata_q <= 32'h0;
            if (a_ill) begin
              err_q   <= ERR_SIZE;
              state_q <= RESP;
            end else if (a_mis) begin
              err_q   <= ERR_MISALIGN;
              state_q <= RESP;
            end else begin
              err_q   <= ERR_OK;
              state_q <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            rdata_q <= wr_q ? 32'h0 : a_rdata;
            err_q   <= ERR_OK;
            state_q <= RESP;
          end else if (cnt_d == TO) begin
            rdata_q <= 32'h0;
            err_q   <= ERR_TIMEOUT;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          if (rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready        = idle & reset;
  assign rsp_valid        = (state_q == RESP);
  assign rsp_rdata        = rdata_q;
  assign rsp_err          = err_q;
  assign mem_valid        = (state_q == REQ);
  assign mem_write_enable = mem_valid & wr_q;
  assign mem_addr         = mem_valid ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wdata        = mem_valid ? a_wdo : 32'h0;
  assign mem_wmask        = mem_valid ? a_wmask : 4'h0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a response scoreboard.
// Expected responses are queued at request time and popped on rsp_valid.
module tb_lsu_mem_master;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        mem_valid;
  logic        mem_write_enable;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ready = 1'b0;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  lsu_mem_master #(.TIMEOUT_CYCLES(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_unsigned     (req_unsigned),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_rdata        (rsp_rdata),
    .rsp_err          (rsp_err),
    .mem_valid        (mem_valid),
    .mem_write_enable (mem_write_enable),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_wmask        (mem_wmask),
    .mem_rdata        (mem_rdata),
    .mem_ready        (mem_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic txn(
    input string       name,
    input logic        wr,
    input logic [1:0]  sz,
    input logic        uns,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [31:0] mdata,
    input int          rdy_dly,
    input int          e_mv,
    input logic [31:0] e_addr,
    input logic [3:0]  e_mask,
    input logic [31:0] e_wd,
    input logic        e_we,
    input logic [31:0] e_rd,
    input logic [1:0]  e_err,
    input int          e_lat,
    input int          stall
  );
    int   mv;
    int   lat;
    exp_t e;
    mv  = 0;
    lat = -1;
    @(negedge clock);
    chk({name, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    sb.push_back('{rdata: e_rd, err: e_err});
    @(posedge clock);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (rsp_valid) begin
        lat = c;
        break;
      end
      if (mem_valid) begin
        mv++;
        if (mv == 1) begin
          chk({name, ".mem_addr"}, mem_addr, e_addr);
          chk({name, ".mem_wmask"}, 32'(mem_wmask), 32'(e_mask));
          chk({name, ".mem_wdata"}, mem_wdata, e_wd);
          chk({name, ".mem_we"}, 32'(mem_write_enable), 32'(e_we));
        end
        if (c - 1 == rdy_dly) begin
          mem_ready = 1'b1;
          mem_rdata = mdata;
        end
      end
      @(posedge clock);
      #1;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
    end
    chk({name, ".latency"}, 32'(lat), 32'(e_lat));
    chk({name, ".mem_cycles"}, 32'(mv), 32'(e_mv));
    e = sb.pop_front();
    if (lat > 0) begin
      for (int s = 0; s <= stall; s++) begin
        if (s > 0) @(negedge clock);
        chk({name, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, ".rsp_rdata"}, rsp_rdata, e.rdata);
        chk({name, ".rsp_err"}, 32'(rsp_err), 32'(e.err));
      end
      rsp_ready = 1'b1;
      @(posedge clock);
      #1 rsp_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.mem_valid", 32'(mem_valid), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.mem_wmask", 32'(mem_wmask), 32'h0);
    chk("rst.rsp_rdata", rsp_rdata, 32'h0);
    chk("rst.rsp_err", 32'(rsp_err), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    #1 chk("rst.release_ready", 32'(req_ready), 32'd1);

    txn("lw", 1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF,
        0, 1, 32'h8000_0004, 4'hF, 32'h0, 1'b0,
        32'hDEAD_BEEF, 2'd0, 2, 0);
    txn("lb_s", 1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0, 32'h8012_3456,
        0, 1, 32'h8000_0000, 4'b1000, 32'h0, 1'b0,
        32'hFFFF_FF80, 2'd0, 2, 5);
    txn("lbu", 1'b0, 2'd0, 1'b1, 32'h8000_0003, 32'h0, 32'h8012_3456,
        1, 2, 32'h8000_0000, 4'b1000, 32'h0, 1'b0,
        32'h0000_0080, 2'd0, 3, 0);
    txn("lh_s", 1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'h0, 32'hF00D_1234,
        0, 1, 32'h8000_0000, 4'b1100, 32'h0, 1'b0,
        32'hFFFF_F00D, 2'd0, 2, 0);
    txn("sh", 1'b1, 2'd1, 1'b0, 32'h8000_0102, 32'h0000_ABCD, 32'h0,
        0, 1, 32'h8000_0100, 4'b1100, 32'hABCD_ABCD, 1'b1,
        32'h0, 2'd0, 2, 0);
    txn("sb", 1'b1, 2'd0, 1'b0, 32'h8000_0101, 32'h1234_5677, 32'hFFFF_FFFF,
        0, 1, 32'h8000_0100, 4'b0010, 32'h7777_7777, 1'b1,
        32'h0, 2'd0, 2, 0);
    txn("lw_mis", 1'b0, 2'd2, 1'b0, 32'h8000_0002, 32'h0, 32'h0,
        0, 0, 32'h0, 4'h0, 32'h0, 1'b0,
        32'h0, 2'd1, 1, 0);
    txn("sz3", 1'b0, 2'd3, 1'b0, 32'h8000_0000, 32'h0, 32'h0,
        0, 0, 32'h0, 4'h0, 32'h0, 1'b0,
        32'h0, 2'd3, 1, 0);
    txn("tmo", 1'b0, 2'd2, 1'b0, 32'h8000_0008, 32'h0, 32'h0,
        -1, 4, 32'h8000_0008, 4'hF, 32'h0, 1'b0,
        32'h0, 2'd2, 5, 0);
    txn("tmo_race", 1'b0, 2'd2, 1'b0, 32'h8000_0008, 32'h0, 32'h1357_9BDF,
        3, 4, 32'h8000_0008, 4'hF, 32'h0, 1'b0,
        32'h1357_9BDF, 2'd0, 5, 0);

    @(negedge clock);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 2'd2;
    req_addr  = 32'h8000_0010;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    chk("arst.mem_valid_before", 32'(mem_valid), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("arst.mem_valid", 32'(mem_valid), 32'd0);
    chk("arst.req_ready", 32'(req_ready), 32'd0);
    chk("arst.rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1 chk("arst.release_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("arst.no_rsp", 32'(rsp_valid), 32'd0);
    end

    chk("sb.empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
